// File: rtl/pulse_train_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_pkg
// Description : Shared definitions for the pulse train generator: state
//               encoding, the FSM state type and default counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_NUM_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_HIGH = ST_HIGH,
        S_LOW  = ST_LOW
    } state_t;

endpackage : pulse_pkg
`default_nettype wire

// File: rtl/pulse_train_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : pulse_train_gen_if
// Description : Control/status bundle of the pulse train generator.
//   iStart    launch strobe          iAbort    abort strobe
//   iHighLen  high phase length H    iLowLen   low phase length L
//   iNum      number of periods N
//   oData     pulse train level      oBusy     burst in progress
//   oDone     completion strobe
//   master: drives the controls (burst requester)
//   slave : the generator itself
// Revision    : 1.0 - initial release
// ============================================================================
interface pulse_train_gen_if
    import pulse_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int NUM_W = DEF_NUM_W
);
    logic             iStart;
    logic             iAbort;
    logic [CNT_W-1:0] iHighLen;
    logic [CNT_W-1:0] iLowLen;
    logic [NUM_W-1:0] iNum;
    logic             oData;
    logic             oBusy;
    logic             oDone;

    modport master (
        output iStart, iAbort, iHighLen, iLowLen, iNum,
        input  oData, oBusy, oDone
    );

    modport slave (
        input  iStart, iAbort, iHighLen, iLowLen, iNum,
        output oData, oBusy, oDone
    );

endinterface : pulse_train_gen_if
`default_nettype wire

// File: rtl/pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module      : pulse_train_gen
// Description : Emits N periods of H cycles high / L cycles low on a
//               registered level output after a one-cycle start strobe.
//   clk    : system clock, all logic on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : pulse_train_gen_if.slave (controls in, oData/oBusy/oDone out)
//   CNT_W / NUM_W must match the widths of the connected interface.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_train_gen
    import pulse_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int NUM_W = DEF_NUM_W
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    pulse_train_gen_if.slave bus
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [NUM_W-1:0] c_NUM_ONE = NUM_W'(1);

    state_t           r_state,    w_state_nxt;
    logic [CNT_W-1:0] r_phase,    w_phase_nxt;
    logic [CNT_W-1:0] r_high_len, w_high_len_nxt;
    logic [CNT_W-1:0] r_low_len,  w_low_len_nxt;
    logic [NUM_W-1:0] r_period,   w_period_nxt;
    logic [NUM_W-1:0] r_num,      w_num_nxt;
    logic             r_data;
    logic             r_busy;
    logic             r_done,     w_done_nxt;

    // Zero lengths are treated as one cycle; the clamped value is latched so
    // every later reload of the phase counter sees a non-zero length.
    logic [CNT_W-1:0] w_high_eff;
    logic [CNT_W-1:0] w_low_eff;
    assign w_high_eff = (bus.iHighLen == '0) ? c_CNT_ONE : bus.iHighLen;
    assign w_low_eff  = (bus.iLowLen  == '0) ? c_CNT_ONE : bus.iLowLen;

    // ------------------------------------------------------------------
    // Next-state / counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_phase_nxt    = r_phase;
        w_high_len_nxt = r_high_len;
        w_low_len_nxt  = r_low_len;
        w_period_nxt   = r_period;
        w_num_nxt      = r_num;
        w_done_nxt     = 1'b0;

        if (bus.iAbort) begin
            // Abort beats everything, including a coincident start.
            w_state_nxt  = S_IDLE;
            w_phase_nxt  = '0;
            w_period_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.iStart) begin
                        w_high_len_nxt = w_high_eff;
                        w_low_len_nxt  = w_low_eff;
                        w_num_nxt      = bus.iNum;
                        w_period_nxt   = '0;
                        if (bus.iNum == '0) begin
                            // Empty burst: report completion without a pulse.
                            w_done_nxt  = 1'b1;
                            w_phase_nxt = '0;
                        end else begin
                            w_state_nxt = S_HIGH;
                            w_phase_nxt = w_high_eff;
                        end
                    end
                end

                S_HIGH: begin
                    if (r_phase <= c_CNT_ONE) begin
                        w_state_nxt = S_LOW;
                        w_phase_nxt = r_low_len;
                    end else begin
                        w_phase_nxt = r_phase - c_CNT_ONE;
                    end
                end

                S_LOW: begin
                    if (r_phase <= c_CNT_ONE) begin
                        // r_num >= 1 here, so r_num-1 never underflows and
                        // r_period never has to reach r_num itself.
                        if (r_period == (r_num - c_NUM_ONE)) begin
                            w_state_nxt  = S_IDLE;
                            w_phase_nxt  = '0;
                            w_period_nxt = '0;
                            w_done_nxt   = 1'b1;
                        end else begin
                            w_state_nxt  = S_HIGH;
                            w_phase_nxt  = r_high_len;
                            w_period_nxt = r_period + c_NUM_ONE;
                        end
                    end else begin
                        w_phase_nxt = r_phase - c_CNT_ONE;
                    end
                end

                default: begin
                    w_state_nxt  = S_IDLE;
                    w_phase_nxt  = '0;
                    w_period_nxt = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and output registers. Outputs are decoded from the next state
    // and then registered, so oData comes straight from a flop.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_phase    <= '0;
            r_high_len <= '0;
            r_low_len  <= '0;
            r_period   <= '0;
            r_num      <= '0;
            r_data     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_high_len <= w_high_len_nxt;
            r_low_len  <= w_low_len_nxt;
            r_period   <= w_period_nxt;
            r_num      <= w_num_nxt;
            r_data     <= (w_state_nxt == S_HIGH);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= w_done_nxt;
        end
    end

    assign bus.oData = r_data;
    assign bus.oBusy = r_busy;
    assign bus.oDone = r_done;

endmodule : pulse_train_gen
`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_train_gen
// Description : Directed self-checking bench for pulse_train_gen. Each step
//               drives the strobes for one cycle and checks the registered
//               outputs of that cycle against hand-computed windows.
//               An edge counter on oData tallies rising/falling edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_train_gen;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pulse_train_gen_if #(.CNT_W(16), .NUM_W(8)) u_if ();

    pulse_train_gen #(.CNT_W(16), .NUM_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter on the pulse train (samples the level held before each edge)
    logic r_prev;
    int   rises;
    int   falls;
    initial begin
        rises = 0;
        falls = 0;
    end
    always @(posedge clk) begin
        if (u_if.oData === 1'b1 && r_prev === 1'b0) rises++;
        if (u_if.oData === 1'b0 && r_prev === 1'b1) falls++;
        r_prev <= u_if.oData;
    end

    task automatic chk(input string tag, input int c, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, c, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int c,
                           input logic ed, input logic eb, input logic edn);
        chk({tag, "_data"}, c, u_if.oData, ed);
        chk({tag, "_busy"}, c, u_if.oBusy, eb);
        chk({tag, "_done"}, c, u_if.oDone, edn);
    endtask

    // One cycle: drive strobes, check this cycle's outputs, advance to #1
    // after the next rising edge.
    task automatic step(input string tag, input int c, input logic st, input logic ab,
                        input logic ed, input logic eb, input logic edn);
        u_if.iStart = st;
        u_if.iAbort = ab;
        chk_out(tag, c, ed, eb, edn);
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int h, input int l, input int n);
        u_if.iHighLen = 16'(h);
        u_if.iLowLen  = 16'(l);
        u_if.iNum     = 8'(n);
    endtask

    // H=3 L=2 N=2, start at 10: high 11-13,16-18; busy 11-20; done 21.
    task automatic basic_burst(input string tag);
        int r0;
        int f0;
        r0 = rises;
        f0 = falls;
        set_len(3, 2, 2);
        for (int c = 0; c <= 23; c++)
            step(tag, c, c == 10, 1'b0,
                 (c >= 11 && c <= 13) || (c >= 16 && c <= 18),
                 (c >= 11 && c <= 20),
                 c == 21);
        chk_int({tag, "_rises"}, rises - r0, 2);
        chk_int({tag, "_falls"}, falls - f0, 2);
    endtask

    initial begin
        int r0;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        u_if.iStart = 1'b0;
        u_if.iAbort = 1'b0;
        set_len(0, 0, 0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 0, 1'b0, 1'b0, 1'b0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic burst
        basic_burst("basic");

        // H=0 L=0 N=1, start at 5: high 6, low 7, done 8
        set_len(0, 0, 1);
        for (int c = 0; c <= 10; c++)
            step("zerolen", c, c == 5, 1'b0, c == 6, (c >= 6 && c <= 7), c == 8);

        // N=0, start at 5: no pulse, done 6
        set_len(3, 3, 0);
        for (int c = 0; c <= 8; c++)
            step("n0", c, c == 5, 1'b0, 1'b0, 1'b0, c == 6);

        // H=4 L=4 N=3 start 0; restart at 6 ignored; iHighLen=9 at 7 ignored
        set_len(4, 4, 3);
        r0 = rises;
        for (int c = 0; c <= 27; c++) begin
            if (c == 7) u_if.iHighLen = 16'd9;
            step("restart", c, c == 0 || c == 6, 1'b0,
                 (c >= 1 && c <= 24) && (((c - 1) % 8) < 4),
                 (c >= 1 && c <= 24),
                 c == 25);
        end
        chk_int("restart_rises", rises - r0, 3);

        // H=5 L=5 N=4 start 0, abort 7, restart 8, abort again at 15
        set_len(5, 5, 4);
        for (int c = 0; c <= 18; c++)
            step("abort", c, c == 0 || c == 8, c == 7 || c == 15,
                 (c >= 1 && c <= 5) || (c >= 9 && c <= 13),
                 (c >= 1 && c <= 7) || (c >= 9 && c <= 15),
                 1'b0);

        // Start and abort together in IDLE: nothing happens
        set_len(2, 2, 2);
        for (int c = 0; c <= 5; c++)
            step("simul", c, c == 1, c == 1, 1'b0, 1'b0, 1'b0);

        // H=1 L=1 N=1 start 0, done 3; start at 3 gives high 4, done 6
        set_len(1, 1, 1);
        for (int c = 0; c <= 8; c++)
            step("b2b", c, c == 0 || c == 3, 1'b0,
                 c == 1 || c == 4,
                 (c >= 1 && c <= 2) || (c >= 4 && c <= 5),
                 c == 3 || c == 6);

        // Async reset in the middle of a HIGH phase
        set_len(3, 2, 2);
        step("arst_pre", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("arst_pre", 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_out("arst_high", 2, 1'b1, 1'b1, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk_out("arst_imm", 2, 1'b0, 1'b0, 1'b0);
        for (int c = 3; c <= 5; c++) begin
            @(posedge clk);
            #1;
            chk_out("arst_hold", c, 1'b0, 1'b0, 1'b0);
        end
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        basic_burst("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pulse_train_gen
`default_nettype wire
